// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the two-CPU snooping MSI coherence bus: bus operations,
// cache block states, bus FSM states and the request-to-operation helper.
package common;

    typedef enum logic [1:0] {
        BUS_RD,
        BUS_RDX,
        BUS_INV
    } bus_op_t;

    typedef enum logic [1:0] {
        ST_INVALID  = 2'b00,
        ST_SHARED   = 2'b01,
        ST_MODIFIED = 2'b10
    } blk_state_t;

    typedef enum logic [1:0] {
        BS_IDLE,
        BS_SNOOP,
        BS_RESOLVE,
        BS_GRANT
    } bus_state_t;

    // An upgrade/invalidate request outranks a write miss, which outranks a read miss.
    function automatic bus_op_t op_from_req(input logic inv, input logic wm);
        if (inv) return BUS_INV;
        if (wm)  return BUS_RDX;
        return BUS_RD;
    endfunction

endpackage

// File: rtl/coherence_bus_ctrl_arb.sv
// Two-requester round-robin picker. A lone requester always wins; on a tie
// the CPU that did not own the bus last time wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       owner_o,
    output logic       valid_o
);

    // Pick the winner from the current requests and the previous owner.
    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) owner_o = ~last_owner_i;
        else                owner_o = req_i[1];
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Bus-side responder for the two-CPU MSI snooping interface. Picks one
// requester, snoops the other CPU for SNOOP_LAT cycles, resolves the data
// source and any invalidate, then grants the bus until the request drops.
module coherence_bus_ctrl
    import common::*;
#(
    parameter int SNOOP_LAT = 2,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        read_miss,
    input  logic [1:0]        write_miss,
    input  logic [1:0]        invalidate,
    input  logic [1:0]        block_state0,
    input  logic [1:0]        block_state1,
    input  logic [1:0]        cpu_search_found,
    input  logic [ADDR_W-1:0] BICO0,
    input  logic [ADDR_W-1:0] BICO1,
    output logic [1:0]        cpu_search,
    output logic [ADDR_W-1:0] BOCI0,
    output logic [ADDR_W-1:0] BOCI1,
    output logic [1:0]        grant,
    output logic [1:0]        cpu_datasel,
    output logic [1:0]        invalidate_from_other_cpu,
    output logic              busy
);

    localparam logic [2:0] SNOOP_LAT_C = 3'(SNOOP_LAT);

    bus_state_t        state_q, state_d;
    bus_op_t           op_q, op_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              found_q, found_d;
    logic              mod_q, mod_d;
    logic [1:0]        datasel_q, datasel_d;

    logic [1:0] req;
    logic       other;
    logic       req_owner;
    logic       snoop_found;
    logic [1:0] snoop_state;
    logic       arb_owner;
    logic       arb_valid;

    assign req         = read_miss | write_miss | invalidate;
    assign other       = ~owner_q;
    assign req_owner   = req[owner_q];
    assign snoop_found = cpu_search_found[other];
    assign snoop_state = other ? block_state1 : block_state0;

    rr_arb2 u_arb (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .owner_o      (arb_owner),
        .valid_o      (arb_valid)
    );

    // Next-state logic for the arbitration / snoop / resolve / grant sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        op_d         = op_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        found_d      = found_q;
        mod_d        = mod_q;
        datasel_d    = datasel_q;

        case (state_q)
            BS_IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_owner;
                    op_d    = op_from_req(invalidate[arb_owner], write_miss[arb_owner]);
                    addr_d  = arb_owner ? BICO1 : BICO0;
                    found_d = 1'b0;
                    mod_d   = 1'b0;
                    cnt_d   = 3'd1;
                    state_d = BS_SNOOP;
                end
            end
            BS_SNOOP: begin
                found_d = found_q | snoop_found;
                mod_d   = mod_q | (snoop_found & (snoop_state == ST_MODIFIED));
                if (!req_owner)                state_d = BS_IDLE;
                else if (cnt_q == SNOOP_LAT_C) state_d = BS_RESOLVE;
                else                           cnt_d   = cnt_q + 3'd1;
            end
            BS_RESOLVE: begin
                datasel_d          = 2'b00;
                datasel_d[owner_q] = mod_q & (op_q != BUS_INV);
                state_d            = BS_GRANT;
            end
            BS_GRANT: begin
                if (!req_owner) begin
                    datasel_d    = 2'b00;
                    last_owner_d = owner_q;
                    state_d      = BS_IDLE;
                end
            end
            default: state_d = BS_IDLE;
        endcase
    end

    // State registers; last_owner resets to CPU1 so CPU0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BS_IDLE;
            op_q         <= BUS_RD;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            addr_q       <= '0;
            cnt_q        <= 3'd0;
            found_q      <= 1'b0;
            mod_q        <= 1'b0;
            datasel_q    <= 2'b00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_d;
            op_q         <= op_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            found_q      <= found_d;
            mod_q        <= mod_d;
            datasel_q    <= datasel_d;
        end
    end

    // Outputs decoded purely from registered state, never from live inputs.
    always_comb begin
        cpu_search                = 2'b00;
        grant                     = 2'b00;
        invalidate_from_other_cpu = 2'b00;
        BOCI0                     = '0;
        BOCI1                     = '0;
        case (state_q)
            BS_SNOOP: begin
                cpu_search[other] = 1'b1;
                if (other) BOCI1 = addr_q;
                else       BOCI0 = addr_q;
            end
            BS_RESOLVE: begin
                invalidate_from_other_cpu[other] = found_q & (op_q != BUS_RD);
            end
            BS_GRANT: begin
                grant[owner_q] = 1'b1;
                if (owner_q) BOCI1 = addr_q;
                else         BOCI0 = addr_q;
            end
            default: ;
        endcase
    end

    assign cpu_datasel = datasel_q;
    assign busy        = (state_q != BS_IDLE);

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: reset state, a table of
// single-requester transactions, hand-written tie/abort/reset sequences and
// randomized traffic against a transaction-level reference model.
module tb_coherence_bus_ctrl;
    import common::*;

    localparam int SNOOP_LAT = 2;
    localparam int ADDR_W    = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        read_miss, write_miss, invalidate;
    logic [1:0]        block_state0, block_state1, cpu_search_found;
    logic [ADDR_W-1:0] BICO0, BICO1;
    logic [1:0]        cpu_search;
    logic [ADDR_W-1:0] BOCI0, BOCI1;
    logic [1:0]        grant, cpu_datasel, invalidate_from_other_cpu;
    logic              busy;

    int   checks = 0;
    int   errors = 0;
    logic last_owner_m;

    typedef struct {
        int          cpu;
        bus_op_t     op;
        logic [10:0] addr;
        logic        fnd;
        logic [1:0]  st;
        logic [1:0]  exp_sel;
        logic [1:0]  exp_inv;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    coherence_bus_ctrl #(.SNOOP_LAT(SNOOP_LAT), .ADDR_W(ADDR_W)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .read_miss                 (read_miss),
        .write_miss                (write_miss),
        .invalidate                (invalidate),
        .block_state0              (block_state0),
        .block_state1              (block_state1),
        .cpu_search_found          (cpu_search_found),
        .BICO0                     (BICO0),
        .BICO1                     (BICO1),
        .cpu_search                (cpu_search),
        .BOCI0                     (BOCI0),
        .BOCI1                     (BOCI1),
        .grant                     (grant),
        .cpu_datasel               (cpu_datasel),
        .invalidate_from_other_cpu (invalidate_from_other_cpu),
        .busy                      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] req_vec();
        return read_miss | write_miss | invalidate;
    endfunction

    function automatic bus_op_t op_of(input int c);
        if (invalidate[c]) return BUS_INV;
        if (write_miss[c]) return BUS_RDX;
        return BUS_RD;
    endfunction

    function automatic logic [10:0] boci_of(input int c);
        return (c == 1) ? BOCI1 : BOCI0;
    endfunction

    task automatic set_op(input int c, input bus_op_t op);
        read_miss[c]  = (op == BUS_RD);
        write_miss[c] = (op == BUS_RDX);
        invalidate[c] = (op == BUS_INV);
    endtask

    task automatic set_rand_bits(input int c);
        logic [2:0] b;
        b = 3'($urandom_range(1, 7));
        read_miss[c]  = b[0];
        write_miss[c] = b[1];
        invalidate[c] = b[2];
    endtask

    task automatic clr_req(input int c);
        read_miss[c]  = 1'b0;
        write_miss[c] = 1'b0;
        invalidate[c] = 1'b0;
    endtask

    task automatic drive_snoop(input int c, input logic f, input logic [1:0] s);
        cpu_search_found[c] = f;
        if (c == 1) block_state1 = s;
        else        block_state0 = s;
    endtask

    // One complete transaction from IDLE through release. The owner comes from
    // the arbitration rule; data source and invalidate come from the snoop
    // responses seen during the snoop window unless the caller supplies them.
    task automatic txn(input bit rnd, input bit has_exp, input logic [1:0] exp_sel_t,
                       input logic [1:0] exp_inv_t, input logic fnd, input logic [1:0] st,
                       input int hold, input string tag);
        logic [1:0]  r, e_sel, e_inv, s;
        logic [10:0] a;
        logic        f, f_any, m_any;
        int          own, oth;
        bus_op_t     op;

        r   = req_vec();
        own = (r == 2'b11) ? (last_owner_m ? 0 : 1) : (r[1] ? 1 : 0);
        oth = 1 - own;
        op  = op_of(own);
        a   = (own == 1) ? BICO1 : BICO0;
        f_any = 1'b0;
        m_any = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 0);
        // Snoop inputs seen while still IDLE must not count.
        if (rnd) drive_snoop(oth, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        for (int k = 1; k <= SNOOP_LAT; k++) begin
            tick();
            check({tag, "_snp_search"}, 32'(cpu_search), 32'(1 << oth));
            check({tag, "_snp_boci_oth"}, 32'(boci_of(oth)), 32'(a));
            check({tag, "_snp_boci_own"}, 32'(boci_of(own)), 0);
            check({tag, "_snp_grant"}, 32'(grant), 0);
            check({tag, "_snp_busy"}, 32'(busy), 1);
            if (rnd) begin
                f = 1'($urandom_range(0, 1));
                s = 2'($urandom_range(0, 3));
                drive_snoop(own, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                set_rand_bits(own);
                if (own == 1) BICO1 = 11'($urandom);
                else          BICO0 = 11'($urandom);
            end else begin
                f = fnd;
                s = st;
            end
            drive_snoop(oth, f, s);
            f_any = f_any | f;
            m_any = m_any | (f & (s == 2'b10));
        end
        if (has_exp) begin
            e_sel = exp_sel_t;
            e_inv = exp_inv_t;
        end else begin
            e_sel = (m_any && op != BUS_INV) ? 2'(1 << own) : 2'b00;
            e_inv = (f_any && op != BUS_RD)  ? 2'(1 << oth) : 2'b00;
        end
        tick();
        check({tag, "_res_inv"}, 32'(invalidate_from_other_cpu), 32'(e_inv));
        check({tag, "_res_search"}, 32'(cpu_search), 0);
        check({tag, "_res_grant"}, 32'(grant), 0);
        if (rnd) drive_snoop(oth, 1'b1, 2'b10);
        tick();
        check({tag, "_gnt_grant"}, 32'(grant), 32'(1 << own));
        check({tag, "_gnt_sel"}, 32'(cpu_datasel), 32'(e_sel));
        check({tag, "_gnt_inv"}, 32'(invalidate_from_other_cpu), 0);
        check({tag, "_gnt_boci_own"}, 32'(boci_of(own)), 32'(a));
        check({tag, "_gnt_boci_oth"}, 32'(boci_of(oth)), 0);
        for (int h = 0; h < hold; h++) begin
            if (rnd && req_vec()[oth] == 1'b0 && $urandom_range(0, 1) == 1) set_rand_bits(oth);
            tick();
            check({tag, "_hold_grant"}, 32'(grant), 32'(1 << own));
            check({tag, "_hold_sel"}, 32'(cpu_datasel), 32'(e_sel));
        end
        clr_req(own);
        tick();
        check({tag, "_rel_grant"}, 32'(grant), 0);
        check({tag, "_rel_sel"}, 32'(cpu_datasel), 0);
        check({tag, "_rel_busy"}, 32'(busy), 0);
        last_owner_m = own[0];
    endtask

    initial begin
        int n;

        tbl[0] = '{0, BUS_RD,  11'h155, 1'b0, 2'b00, 2'b00, 2'b00};
        tbl[1] = '{1, BUS_RDX, 11'h0A3, 1'b1, 2'b10, 2'b10, 2'b01};
        tbl[2] = '{0, BUS_INV, 11'h2F0, 1'b1, 2'b01, 2'b00, 2'b10};
        tbl[3] = '{1, BUS_RD,  11'h7FF, 1'b1, 2'b10, 2'b10, 2'b00};
        tbl[4] = '{0, BUS_INV, 11'h001, 1'b1, 2'b10, 2'b00, 2'b10};
        tbl[5] = '{0, BUS_RDX, 11'h444, 1'b0, 2'b10, 2'b00, 2'b00};

        rst_n = 1'b0;
        read_miss = '0; write_miss = '0; invalidate = '0;
        block_state0 = '0; block_state1 = '0; cpu_search_found = '0;
        BICO0 = '0; BICO1 = '0;
        last_owner_m = 1'b1;

        #12;
        check("rst_grant", 32'(grant), 0);
        check("rst_search", 32'(cpu_search), 0);
        check("rst_sel", 32'(cpu_datasel), 0);
        check("rst_inv", 32'(invalidate_from_other_cpu), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_boci", 32'({BOCI1, BOCI0}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Tie straight out of reset: CPU0 first, waiting CPU1 next.
        BICO0 = 11'h111; BICO1 = 11'h222;
        set_op(0, BUS_RD); set_op(1, BUS_RD);
        txn(0, 0, 2'b00, 2'b00, 1'b0, 2'b00, 2, "tieA0");
        txn(0, 0, 2'b00, 2'b00, 1'b0, 2'b00, 1, "tieA1");
        // CPU0 alone, then a tie must go to CPU1, then CPU0.
        set_op(0, BUS_RD);
        txn(0, 0, 2'b00, 2'b00, 1'b0, 2'b00, 0, "solo0");
        set_op(0, BUS_RD); set_op(1, BUS_RD);
        txn(0, 0, 2'b00, 2'b00, 1'b0, 2'b00, 1, "tieB1");
        txn(0, 0, 2'b00, 2'b00, 1'b0, 2'b00, 1, "tieB0");

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].cpu == 1) BICO1 = tbl[i].addr;
            else                 BICO0 = tbl[i].addr;
            set_op(tbl[i].cpu, tbl[i].op);
            txn(0, 1, tbl[i].exp_sel, tbl[i].exp_inv, tbl[i].fnd, tbl[i].st, 1,
                $sformatf("vec%0d", i));
        end

        // Abort: request drops in the second snoop cycle with a hit that would
        // otherwise cause an invalidate.
        BICO0 = 11'h3A5;
        set_op(0, BUS_RDX);
        drive_snoop(1, 1'b1, 2'b10);
        tick();
        check("abort_s1", 32'(cpu_search), 32'(2'b10));
        tick();
        check("abort_s2", 32'(cpu_search), 32'(2'b10));
        clr_req(0);
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_search", 32'(cpu_search), 0);
        for (int k = 0; k < 3; k++) begin
            check("abort_grant", 32'(grant), 0);
            check("abort_inv", 32'(invalidate_from_other_cpu), 0);
            tick();
        end
        drive_snoop(1, 1'b0, 2'b00);

        // Asynchronous reset while CPU1 holds the bus with cache-to-cache data.
        BICO1 = 11'h0A3;
        set_op(1, BUS_RDX);
        drive_snoop(0, 1'b1, 2'b10);
        for (int k = 0; k < SNOOP_LAT + 2; k++) tick();
        check("rstg_pre_grant", 32'(grant), 32'(2'b10));
        check("rstg_pre_sel", 32'(cpu_datasel), 32'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstg_grant", 32'(grant), 0);
        check("rstg_sel", 32'(cpu_datasel), 0);
        check("rstg_busy", 32'(busy), 0);
        check("rstg_inv", 32'(invalidate_from_other_cpu), 0);
        clr_req(1);
        drive_snoop(0, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        last_owner_m = 1'b1;
        tick();
        set_op(1, BUS_RD);
        txn(0, 0, 2'b00, 2'b00, 1'b0, 2'b00, 1, "post_rst");

        // Randomized traffic against the transaction-level model.
        for (int it = 0; it < 150; it++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 2) != 0) set_rand_bits(c);
            end
            if (req_vec() == 2'b00) set_rand_bits(int'($urandom_range(0, 1)));
            BICO0 = 11'($urandom);
            BICO1 = 11'($urandom);
            n = 0;
            while (req_vec() != 2'b00 && n < 4) begin
                txn(1, 0, 2'b00, 2'b00, 1'b0, 2'b00, int'($urandom_range(0, 3)), "rnd");
                n++;
            end
            read_miss = '0; write_miss = '0; invalidate = '0;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
